// File: rtl/axis_bram_reader_pkg.sv
// -----------------------------------------------------------------------------
// axis_bram_reader_pkg
// Shared types and sizing helpers for the BRAM-to-AXI4-Stream reader.
//   state_e       : reader FSM encoding (IDLE / ISSUE / DRAIN)
//   fifo_depth()  : output FIFO depth; one slot per read that can be in flight
//                   plus one so issue can continue while the head waits.
//   credit_width(): width of a counter that must hold 0..fifo_depth.
// -----------------------------------------------------------------------------
package axis_bram_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic int fifo_depth(input int read_latency);
        return read_latency + 1;
    endfunction

    function automatic int credit_width(input int read_latency);
        return $clog2(fifo_depth(read_latency) + 1);
    endfunction

endpackage

// File: rtl/axis_bram_reader_if.sv
// -----------------------------------------------------------------------------
// Bus interfaces used by axis_bram_reader.
//   axis_bram_reader_if      : AXI4-Stream beat (tdata/tvalid/tready/tlast).
//                              master = stream source, slave = stream sink.
//   axis_bram_reader_bram_if : BRAM read port (clk/rst/en/addr/rddata).
//                              master = reader, slave = memory.
// -----------------------------------------------------------------------------
interface axis_bram_reader_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

interface axis_bram_reader_bram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) ();
    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] rddata;

    modport master (output clk, output rst, output en, output addr, input rddata);
    modport slave  (input clk, input rst, input en, input addr, output rddata);
endinterface

// File: rtl/axis_bram_reader_fifo.sv
// -----------------------------------------------------------------------------
// axis_bram_reader_fifo
// Small register FIFO holding {last, data} words returned by the BRAM.
// Ports:
//   aclk, areset : clock, asynchronous active-high reset
//   push, din    : write request / word (dropped if full with no pop)
//   pop          : read request (ignored while empty)
//   dout         : head word, meaningful only while !empty
//   empty, full  : occupancy flags; push+pop in the same cycle when full is legal
// -----------------------------------------------------------------------------
module axis_bram_reader_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 2
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap explicitly because DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // NOTE: storage is deliberately left out of reset; empty/count gate every
    // use of it, so resetting it would only add reset fan-out for nothing.
    always_ff @(posedge aclk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/axis_bram_reader.sv
// -----------------------------------------------------------------------------
// axis_bram_reader
// Streams BRAM addresses 0..cfg_data out as AXI4-Stream beats, tlast on the
// beat for address cfg_data. Reads are issued only when a FIFO slot is
// guaranteed (credit scheme), so backpressure never drops or repeats words.
//
// Ports:
//   aclk, areset      : clock, asynchronous active-high reset
//   cfg_data          : last address to read, sampled on an accepted start
//   start             : one-cycle pulse, ignored while busy
//   busy              : high from the accepted start until the tlast handshake
//   sts_data          : next address to be issued
//   m_axis            : AXI4-Stream master (tdata/tvalid/tready/tlast)
//   bram_porta        : BRAM read port; rddata valid BRAM_READ_LATENCY
//                       cycles after en
//
// AXIS_TDATA_WIDTH must equal BRAM_DATA_WIDTH; BRAM_READ_LATENCY is 1 or 2.
//
// Build option AXIS_BRAM_READER_CONTINUOUS_EN: after issuing the last address
// the reader wraps to 0, re-samples cfg_data and keeps streaming until reset.
// -----------------------------------------------------------------------------
module axis_bram_reader
    import axis_bram_reader_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH  = 32,
    parameter int BRAM_DATA_WIDTH   = 32,
    parameter int BRAM_ADDR_WIDTH   = 10,
    parameter int BRAM_READ_LATENCY = 1
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [BRAM_ADDR_WIDTH-1:0] cfg_data,
    input  logic                       start,
    output logic                       busy,
    output logic [BRAM_ADDR_WIDTH-1:0] sts_data,
    axis_bram_reader_if.master         m_axis,
    axis_bram_reader_bram_if.master    bram_porta
);

    localparam int DEPTH = fifo_depth(BRAM_READ_LATENCY);
    localparam int CW    = credit_width(BRAM_READ_LATENCY);
    localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);

    state_e                     state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [BRAM_ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
    logic [CW-1:0]              credit_q;
    logic [BRAM_READ_LATENCY-1:0] pipe_vld_q;
    logic [BRAM_READ_LATENCY-1:0] pipe_last_q;

    logic                       issue;
    logic                       issue_last;
    logic                       can_issue;
    logic                       pop;
    logic                       fifo_push;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [BRAM_DATA_WIDTH:0]   fifo_dout;
    logic                       head_last;
    logic [AXIS_TDATA_WIDTH-1:0] head_data;

    // A pop frees a slot this very cycle, so a full credit count may still
    // issue when the head is being accepted; this keeps 1 beat/cycle.
    assign pop       = m_axis.tvalid & m_axis.tready;
    assign can_issue = (credit_q < CREDIT_MAX) | pop;

    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_addr_d = cfg_data;
                    addr_d      = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (can_issue) begin
                    issue      = 1'b1;
                    issue_last = (addr_q == last_addr_q);
                    addr_d     = addr_q + 1'b1;
                    if (issue_last) begin
`ifdef AXIS_BRAM_READER_CONTINUOUS_EN
                        addr_d      = '0;
                        last_addr_d = cfg_data;
`else
                        state_d     = DRAIN;
`endif
                    end
                end
            end
            DRAIN: begin
                if (pop && head_last) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            credit_q    <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            if (issue && !pop)      credit_q <= credit_q + 1'b1;
            else if (!issue && pop) credit_q <= credit_q - 1'b1;
            // In-flight tracker: the entry leaves the last stage exactly when
            // the BRAM presents the matching rddata.
            pipe_vld_q[0]  <= issue;
            pipe_last_q[0] <= issue_last;
            for (int i = 1; i < BRAM_READ_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end
        end
    end

    assign fifo_push = pipe_vld_q[BRAM_READ_LATENCY-1];

    axis_bram_reader_fifo #(
        .WIDTH (BRAM_DATA_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk   (aclk),
        .areset (areset),
        .push   (fifo_push),
        .din    ({pipe_last_q[BRAM_READ_LATENCY-1], bram_porta.rddata}),
        .pop    (m_axis.tready),
        .dout   (fifo_dout),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    assign head_last = fifo_dout[BRAM_DATA_WIDTH];
    assign head_data = fifo_dout[BRAM_DATA_WIDTH-1:0];

    assign m_axis.tvalid = ~fifo_empty;
    assign m_axis.tdata  = head_data;
    assign m_axis.tlast  = ~fifo_empty & head_last;

    assign bram_porta.clk  = aclk;
    assign bram_porta.rst  = areset;
    assign bram_porta.en   = issue;
    assign bram_porta.addr = addr_q;

    assign busy     = (state_q != IDLE);
    assign sts_data = addr_q;

endmodule

// File: tb/tb_axis_bram_reader.sv
// -----------------------------------------------------------------------------
// tb_axis_bram_reader
// Two readers run side by side from the same start/cfg_data/areset:
//   u_d1 : read latency 1, tready held high
//   u_d2 : read latency 2, tready following a 1,0,0,1 pattern
// BRAM models return mem[i] = i + 0x100. A vector table drives single passes;
// hand-written sequences cover start/cfg changes while busy and mid-pass reset.
// With AXIS_BRAM_READER_CONTINUOUS_EN defined the repeating mode is exercised.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_bram_reader;

    logic       aclk = 1'b0;
    logic       areset;
    logic       start;
    logic [9:0] cfg_data;
    logic [1:0] busy_w;
    logic [9:0] sts0, sts1;
    logic       tready [2];

    axis_bram_reader_if      #(.DATA_WIDTH(32))                 ax1 ();
    axis_bram_reader_if      #(.DATA_WIDTH(32))                 ax2 ();
    axis_bram_reader_bram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) br1 ();
    axis_bram_reader_bram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) br2 ();

    axis_bram_reader #(.BRAM_READ_LATENCY(1)) u_d1 (
        .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .start(start),
        .busy(busy_w[0]), .sts_data(sts0), .m_axis(ax1), .bram_porta(br1)
    );
    axis_bram_reader #(.BRAM_READ_LATENCY(2)) u_d2 (
        .aclk(aclk), .areset(areset), .cfg_data(cfg_data), .start(start),
        .busy(busy_w[1]), .sts_data(sts1), .m_axis(ax2), .bram_porta(br2)
    );

    always #5 aclk = ~aclk;

    assign ax1.tready = tready[0];
    assign ax2.tready = tready[1];

    // BRAM models: latency 1 and latency 2 (extra output register).
    logic [31:0] bram2_stage;
    always @(posedge aclk) if (br1.en) br1.rddata <= 32'h100 + 32'(br1.addr);
    always @(posedge aclk) begin
        if (br2.en) bram2_stage <= 32'h100 + 32'(br2.addr);
        br2.rddata <= bram2_stage;
    end

    logic        tv [2];
    logic        tl [2];
    logic [31:0] td [2];
    logic        en_w [2];
    logic [9:0]  addr_w [2];
    assign tv[0] = ax1.tvalid; assign tv[1] = ax2.tvalid;
    assign tl[0] = ax1.tlast;  assign tl[1] = ax2.tlast;
    assign td[0] = ax1.tdata;  assign td[1] = ax2.tdata;
    assign en_w[0] = br1.en;   assign en_w[1] = br2.en;
    assign addr_w[0] = br1.addr; assign addr_w[1] = br2.addr;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // ---------------- monitor (negedge, away from the active edge) ----------
    logic [32:0] beat_mem [2][4096];
    int          hs_cyc   [2][4096];
    int          nbeats   [2] = '{0, 0};
    logic        stalled  [2] = '{1'b0, 1'b0};
    logic [32:0] held     [2];
    int          stall_checks = 0;
    int          stall_errs   = 0;
    int          ovf_errs     = 0;
    int          credit_errs  = 0;

    always @(negedge aclk) begin
        for (int d = 0; d < 2; d++) begin
            if (areset) begin
                stalled[d] = 1'b0;
            end else begin
                if (stalled[d]) begin
                    stall_checks++;
                    if (!tv[d] || {tl[d], td[d]} !== held[d]) stall_errs++;
                end
                if (tv[d] && tready[d]) begin
                    if (nbeats[d] < 4096) begin
                        beat_mem[d][nbeats[d]] = {tl[d], td[d]};
                        hs_cyc[d][nbeats[d]]   = cyc;
                    end
                    nbeats[d]++;
                end
                stalled[d] = tv[d] & ~tready[d];
                held[d]    = {tl[d], td[d]};
            end
        end
        if (u_d1.fifo_push && u_d1.fifo_full && !(tv[0] && tready[0])) ovf_errs++;
        if (u_d2.fifo_push && u_d2.fifo_full && !(tv[1] && tready[1])) ovf_errs++;
        // Credit must equal in-flight reads plus FIFO occupancy.
        if (32'(u_d1.credit_q) != 32'(u_d1.pipe_vld_q[0]) + 32'(u_d1.u_fifo.count_q))
            credit_errs++;
        if (32'(u_d2.credit_q) != 32'(u_d2.pipe_vld_q[0]) + 32'(u_d2.pipe_vld_q[1])
                                  + 32'(u_d2.u_fifo.count_q))
            credit_errs++;
    end

    // ---------------- checking ----------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [9:0]  cfg;
        int          restart_at;  // loop index for stray start pulses, -1 none
        int          abort_at;    // loop index for areset, -1 none
        int          exp_beats;
        logic [31:0] exp_last;
    } vec_t;

    int       base [2];
    int       first_cyc [2];
    int       fall_cyc [2];
    int       start_cyc;
    bit       done;
    bit [3:0] pat = 4'b1001;

    task automatic run_pass(input logic [9:0] cfg, input int restart_at, input int abort_at);
        logic [1:0] bprev;
        for (int d = 0; d < 2; d++) begin
            base[d] = nbeats[d]; first_cyc[d] = -1; fall_cyc[d] = -1;
        end
        cfg_data = cfg;
        start    = 1'b1;
        @(posedge aclk); #1;
        start_cyc = cyc;
        start     = 1'b0;
        done      = 1'b0;
        bprev     = busy_w;
        for (int i = 0; i < 6000; i++) begin
            for (int d = 0; d < 2; d++)
                if (tv[d] && first_cyc[d] < 0) first_cyc[d] = cyc;
            tready[1] = pat[i % 4];
            start     = (restart_at >= 0) && (i == 3 || i == restart_at);
            if (restart_at >= 0 && i == 3) cfg_data = 10'd2;
            if (restart_at >= 0 && i == 4) cfg_data = 10'd15;
            if (i == abort_at) begin
                areset = 1'b1;
                #1;
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("abort_tvalid_d%0d", d), 64'(tv[d]), 64'd0);
                    check($sformatf("abort_busy_d%0d", d), 64'(busy_w[d]), 64'd0);
                    check($sformatf("abort_en_d%0d", d), 64'(en_w[d]), 64'd0);
                end
                done = 1'b1;
                break;
            end
            @(posedge aclk); #1;
            for (int d = 0; d < 2; d++)
                if (bprev[d] && !busy_w[d] && fall_cyc[d] < 0) fall_cyc[d] = cyc;
            bprev = busy_w;
            if (busy_w == 2'b00) begin
                done = 1'b1;
                break;
            end
        end
        start     = 1'b0;
        tready[1] = 1'b1;
        check("pass_completed", 64'(done), 64'd1);
    endtask

    task automatic check_pass(input int d, input vec_t v);
        int n, seq_err, last_err, gaps, lat;
        n = nbeats[d] - base[d];
        check($sformatf("beats_d%0d", d), 64'(n), 64'(v.exp_beats));
        seq_err = 0; last_err = 0; gaps = 0;
        for (int k = 0; k < n && base[d] + k < 4096; k++) begin
            if (beat_mem[d][base[d]+k][31:0] !== 32'h100 + 32'(k)) seq_err++;
            if (beat_mem[d][base[d]+k][32] !== (k == v.exp_beats - 1)) last_err++;
            if (k > 0 && hs_cyc[d][base[d]+k] != hs_cyc[d][base[d]+k-1] + 1) gaps++;
        end
        check($sformatf("data_seq_errs_d%0d", d), 64'(seq_err), 64'd0);
        check($sformatf("tlast_pos_errs_d%0d", d), 64'(last_err), 64'd0);
        if (n > 0 && base[d] + n - 1 < 4096) begin
            check($sformatf("last_data_d%0d", d), 64'(beat_mem[d][base[d]+n-1][31:0]),
                  64'(v.exp_last));
            check($sformatf("busy_fall_d%0d", d), 64'(fall_cyc[d]),
                  64'(hs_cyc[d][base[d]+n-1] + 1));
        end
        lat = first_cyc[d] - start_cyc;
        check($sformatf("first_valid_lat_d%0d", d), 64'(lat), 64'(d + 2));
        if (d == 0) check("gapless_d0", 64'(gaps), 64'd0);
        check($sformatf("sts_data_d%0d", d), 64'(d == 0 ? sts0 : sts1),
              64'((32'(v.cfg) + 1) % 1024));
    endtask

    vec_t vecs [7];

    initial begin
        vecs[0] = '{cfg: 10'd7,    restart_at: -1, abort_at: -1, exp_beats: 8,    exp_last: 32'h107};
        vecs[1] = '{cfg: 10'd0,    restart_at: -1, abort_at: -1, exp_beats: 1,    exp_last: 32'h100};
        vecs[2] = '{cfg: 10'd1,    restart_at: -1, abort_at: -1, exp_beats: 2,    exp_last: 32'h101};
        vecs[3] = '{cfg: 10'd7,    restart_at:  9, abort_at: -1, exp_beats: 8,    exp_last: 32'h107};
        vecs[4] = '{cfg: 10'd7,    restart_at: -1, abort_at:  6, exp_beats: 0,    exp_last: 32'h0};
        vecs[5] = '{cfg: 10'd7,    restart_at: -1, abort_at: -1, exp_beats: 8,    exp_last: 32'h107};
        vecs[6] = '{cfg: 10'd1023, restart_at: -1, abort_at: -1, exp_beats: 1024, exp_last: 32'h4FF};

        areset    = 1'b1;
        start     = 1'b0;
        cfg_data  = '0;
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_busy_d%0d", d), 64'(busy_w[d]), 64'd0);
            check($sformatf("rst_sts_d%0d", d), 64'(d == 0 ? sts0 : sts1), 64'd0);
            check($sformatf("rst_tvalid_d%0d", d), 64'(tv[d]), 64'd0);
            check($sformatf("rst_tlast_d%0d", d), 64'(tl[d]), 64'd0);
            check($sformatf("rst_en_d%0d", d), 64'(en_w[d]), 64'd0);
            check($sformatf("rst_addr_d%0d", d), 64'(addr_w[d]), 64'd0);
        end
        areset = 1'b0;
        repeat (2) @(posedge aclk);
        #1;

`ifdef AXIS_BRAM_READER_CONTINUOUS_EN
        begin
            int busy_drop, seq_err, last_err, n;
            busy_drop = 0;
            base[0] = nbeats[0]; base[1] = nbeats[1];
            cfg_data = 10'd3;
            start    = 1'b1;
            @(posedge aclk); #1;
            start = 1'b0;
            for (int i = 0; i < 400; i++) begin
                if (busy_w != 2'b11) busy_drop++;
                tready[1] = pat[i % 4];
                @(posedge aclk); #1;
                if (nbeats[0] - base[0] >= 12 && nbeats[1] - base[1] >= 12) break;
            end
            tready[1] = 1'b1;
            check("busy_held_drops", 64'(busy_drop), 64'd0);
            for (int d = 0; d < 2; d++) begin
                n = nbeats[d] - base[d];
                check($sformatf("cont_beats_ge12_d%0d", d), 64'(n >= 12), 64'd1);
                seq_err = 0; last_err = 0;
                for (int k = 0; k < 12 && k < n; k++) begin
                    if (beat_mem[d][base[d]+k][31:0] !== 32'h100 + 32'(k % 4)) seq_err++;
                    if (beat_mem[d][base[d]+k][32] !== (k % 4 == 3)) last_err++;
                end
                check($sformatf("cont_seq_errs_d%0d", d), 64'(seq_err), 64'd0);
                check($sformatf("cont_tlast_errs_d%0d", d), 64'(last_err), 64'd0);
            end
            areset = 1'b1;
            #1;
            check("cont_stop_busy", 64'(busy_w), 64'd0);
            repeat (2) @(posedge aclk);
            #1;
            areset = 1'b0;
        end
`else
        for (int vi = 0; vi < 7; vi++) begin
            run_pass(vecs[vi].cfg, vecs[vi].restart_at, vecs[vi].abort_at);
            if (vecs[vi].abort_at >= 0) begin
                repeat (2) @(posedge aclk);
                #1;
                areset = 1'b0;
                repeat (2) @(posedge aclk);
                #1;
                check("post_abort_tvalid", 64'({tv[0], tv[1]}), 64'd0);
            end else begin
                repeat (3) @(posedge aclk);
                #1;
                check($sformatf("idle_after_pass_v%0d", vi), 64'(busy_w), 64'd0);
                check_pass(0, vecs[vi]);
                check_pass(1, vecs[vi]);
            end
        end
        check("stalls_observed", 64'(stall_checks > 0), 64'd1);
`endif

        check("stall_hold_errs", 64'(stall_errs), 64'd0);
        check("fifo_overflow_errs", 64'(ovf_errs), 64'd0);
        check("credit_track_errs", 64'(credit_errs), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
